// File: rtl/lector_mes_rtc_pkg.sv
// Shared definitions for the RTC register readers: FSM encodings, RTC register map,
// bus payload and BCD month limits.
package lector_mes_rtc_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned MES_W      = 4;
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned T_FASE_DEF = 10;

   // RTC register map (address phase values)
   localparam logic [BYTE_W-1:0] RTC_DIR_SEG    = 8'h22;
   localparam logic [BYTE_W-1:0] RTC_DIR_MIN    = 8'h23;
   localparam logic [BYTE_W-1:0] RTC_DIR_HORA   = 8'h24;
   localparam logic [BYTE_W-1:0] RTC_DIR_MES    = 8'h25;
   localparam logic [BYTE_W-1:0] RTC_DIR_DIA    = 8'h26;
   localparam logic [BYTE_W-1:0] RTC_DIR_SEMANA = 8'h27;
   localparam logic [BYTE_W-1:0] RTC_DIR_ANO    = 8'h28;

   localparam logic [BYTE_W-1:0] MES_BCD_MIN = 8'h01;
   localparam logic [BYTE_W-1:0] MES_BCD_MAX = 8'h12;

   typedef enum logic [2:0] {
      REPOSO = 3'd0,
      DIR    = 3'd1,
      GUARDA = 3'd2,
      LECT   = 3'd3,
      FIN    = 3'd4
   } estado_t;

   typedef struct packed {
      logic              cs_n;
      logic              rd_n;
      logic              wr_n;
      logic              ad_n;
      logic              ad_oe;
      logic [BYTE_W-1:0] ad_out;
   } bus_rtc_t;

   localparam bus_rtc_t BUS_REPOSO = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_n: 1'b1,
                                       ad_oe: 1'b0, ad_out: '0};

endpackage

// File: rtl/lector_mes_rtc_if.sv
// Multiplexed address/data bus of the external RTC (CS#, RD#, WR#, A/D#, 8-bit AD).
interface lector_mes_rtc_if;

   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic       ad_n;
   logic       ad_oe;
   logic [7:0] ad_out;
   logic [7:0] ad_in;

   modport master (
      output cs_n, rd_n, wr_n, ad_n, ad_oe, ad_out,
      input  ad_in
   );

   modport slave (
      input  cs_n, rd_n, wr_n, ad_n, ad_oe, ad_out,
      output ad_in
   );

endinterface

// File: rtl/lector_mes_rtc_bcd_a_mes.sv
// Combinational BCD month check (01..12) and conversion to month index 0..11.
module bcd_a_mes
   import lector_mes_rtc_pkg::*;
(
   input  logic [BYTE_W-1:0] bcd,
   output logic              valido_c,
   output logic [MES_W-1:0]  indice_c
);

   logic [3:0] d1;
   logic [3:0] d0;

   assign d1 = bcd[7:4];
   assign d0 = bcd[3:0];

   // Both digits must be decimal before the range compare is meaningful
   assign valido_c = (d1 <= 4'd9) && (d0 <= 4'd9) &&
                     (bcd >= MES_BCD_MIN) && (bcd <= MES_BCD_MAX);

   assign indice_c = d1[0] ? MES_W'(d0 + 4'd9) : MES_W'(d0 - 4'd1);

endmodule

// File: rtl/lector_mes_rtc.sv
// Reads the RTC month register over the multiplexed bus, validates the BCD byte and
// publishes it as BCD and as a 0..11 index with a one-cycle valid/error pulse.
module lector_mes_rtc
   import lector_mes_rtc_pkg::*;
#(
   parameter logic [BYTE_W-1:0] DIR_MES = RTC_DIR_MES,
   parameter int unsigned       T_FASE  = T_FASE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iniciar,
   output logic              ocupado,
   lector_mes_rtc_if.master  bus,
   output logic [BYTE_W-1:0] mes_bcd,
   output logic [MES_W-1:0]  mes_bin,
   output logic              dato_valido,
   output logic              error_bcd
);

   localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(T_FASE - 1);

   estado_t           estado_q;
   estado_t           estado_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   bus_rtc_t          bus_q;
   bus_rtc_t          bus_d;
   logic              ocupado_d;
   logic              dato_valido_d;
   logic              error_bcd_d;
   logic [BYTE_W-1:0] mes_bcd_d;
   logic [MES_W-1:0]  mes_bin_d;
   logic              valido_c;
   logic [MES_W-1:0]  indice_c;
   logic              fin_fase_c;

   bcd_a_mes u_bcd_a_mes (
      .bcd      (bus.ad_in),
      .valido_c (valido_c),
      .indice_c (indice_c)
   );

   assign fin_fase_c = (cnt_q == CNT_ULT);

   // Next state, phase counter and next values of every registered output
   always_comb begin
      estado_d      = estado_q;
      cnt_d         = cnt_q + CNT_W'(1);
      mes_bcd_d     = mes_bcd;
      mes_bin_d     = mes_bin;
      dato_valido_d = 1'b0;
      error_bcd_d   = 1'b0;
      bus_d         = BUS_REPOSO;

      case (estado_q)
         REPOSO: begin
            cnt_d = '0;
            if (iniciar) estado_d = DIR;
         end
         DIR: begin
            if (fin_fase_c) begin
               estado_d = GUARDA;
               cnt_d    = '0;
            end
         end
         GUARDA: begin
            if (fin_fase_c) begin
               estado_d = LECT;
               cnt_d    = '0;
            end
         end
         LECT: begin
            // Decode on the capture edge so the pulse lands in the single FIN cycle
            if (fin_fase_c) begin
               estado_d = FIN;
               cnt_d    = '0;
               if (valido_c) begin
                  mes_bcd_d     = bus.ad_in;
                  mes_bin_d     = indice_c;
                  dato_valido_d = 1'b1;
               end else begin
                  error_bcd_d = 1'b1;
               end
            end
         end
         FIN: begin
            estado_d = REPOSO;
            cnt_d    = '0;
         end
         default: begin
            estado_d = REPOSO;
            cnt_d    = '0;
         end
      endcase

      case (estado_d)
         DIR:     bus_d = '{cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, ad_n: 1'b0,
                            ad_oe: 1'b1, ad_out: DIR_MES};
         LECT:    bus_d = '{cs_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1, ad_n: 1'b1,
                            ad_oe: 1'b0, ad_out: '0};
         default: bus_d = BUS_REPOSO;
      endcase

      ocupado_d = (estado_d != REPOSO);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q    <= REPOSO;
         cnt_q       <= '0;
         bus_q       <= BUS_REPOSO;
         ocupado     <= 1'b0;
         mes_bcd     <= MES_BCD_MIN;
         mes_bin     <= '0;
         dato_valido <= 1'b0;
         error_bcd   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         cnt_q       <= cnt_d;
         bus_q       <= bus_d;
         ocupado     <= ocupado_d;
         mes_bcd     <= mes_bcd_d;
         mes_bin     <= mes_bin_d;
         dato_valido <= dato_valido_d;
         error_bcd   <= error_bcd_d;
      end
   end

   assign bus.cs_n   = bus_q.cs_n;
   assign bus.rd_n   = bus_q.rd_n;
   assign bus.wr_n   = bus_q.wr_n;
   assign bus.ad_n   = bus_q.ad_n;
   assign bus.ad_oe  = bus_q.ad_oe;
   assign bus.ad_out = bus_q.ad_out;

endmodule

// File: tb/tb_lector_mes_rtc.sv
// Bench for lector_mes_rtc: table of month reads on T_FASE=10 and T_FASE=2 instances,
// plus back-to-back, ignored-request and mid-transaction reset sequences.
module tb_lector_mes_rtc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst10, rst2, ini10, ini2;
   logic       oc10, oc2, dv10, dv2, er10, er2;
   logic [7:0] bcd10, bcd2;
   logic [3:0] bin10, bin2;

   lector_mes_rtc_if bus10 ();
   lector_mes_rtc_if bus2 ();

   lector_mes_rtc #(.DIR_MES(8'h25), .T_FASE(10)) u_dut10 (
      .clk(clk), .reset(rst10), .iniciar(ini10), .ocupado(oc10), .bus(bus10),
      .mes_bcd(bcd10), .mes_bin(bin10), .dato_valido(dv10), .error_bcd(er10));

   lector_mes_rtc #(.DIR_MES(8'h25), .T_FASE(2)) u_dut2 (
      .clk(clk), .reset(rst2), .iniciar(ini2), .ocupado(oc2), .bus(bus2),
      .mes_bcd(bcd2), .mes_bin(bin2), .dato_valido(dv2), .error_bcd(er2));

   typedef struct packed {
      logic       cs_n, rd_n, wr_n, ad_n, ad_oe;
      logic [7:0] ad_out;
      logic       ocupado, dv, err;
      logic [7:0] mes_bcd;
      logic [3:0] mes_bin;
   } obs_t;

   obs_t obs [2];
   assign obs[0] = {bus10.cs_n, bus10.rd_n, bus10.wr_n, bus10.ad_n, bus10.ad_oe, bus10.ad_out,
                    oc10, dv10, er10, bcd10, bin10};
   assign obs[1] = {bus2.cs_n, bus2.rd_n, bus2.wr_n, bus2.ad_n, bus2.ad_oe, bus2.ad_out,
                    oc2, dv2, er2, bcd2, bin2};

   typedef struct {
      logic [7:0] ad;
      bit         ok;
      logic [7:0] bcd;
      logic [3:0] bin;
   } vec_t;

   vec_t tab [12];
   int   n_err = 0;
   int   n_chk = 0;
   int   viol  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_ini(input int d, input logic v);
      if (d == 0) ini10 = v; else ini2 = v;
   endtask

   task automatic set_ad(input int d, input logic [7:0] v);
      if (d == 0) bus10.ad_in = v; else bus2.ad_in = v;
   endtask

   // Expected bus strobes/ocupado for cycle c after acceptance, phase length t
   function automatic bit bus_ok(input obs_t o, input int c, input int t);
      logic [4:0] s;
      logic       oc;
      if (c <= t)              begin s = 5'b01001; oc = 1'b1; end
      else if (c <= 2 * t)     begin s = 5'b11110; oc = 1'b1; end
      else if (c <= 3 * t)     begin s = 5'b00110; oc = 1'b1; end
      else if (c == 3 * t + 1) begin s = 5'b11110; oc = 1'b1; end
      else                     begin s = 5'b11110; oc = 1'b0; end
      return ({o.cs_n, o.rd_n, o.wr_n, o.ad_n, o.ad_oe} == s) && (o.ocupado == oc) &&
             (!s[0] || o.ad_out == 8'h25);
   endfunction

   // One read: pulse iniciar, then watch 3t+4 cycles
   task automatic txn(input int d, input int t, input logic [7:0] ad,
                      output int lat, output int ndv, output int nerr, output int bad);
      @(negedge clk);
      set_ad(d, ad);
      set_ini(d, 1'b1);
      @(negedge clk);
      set_ini(d, 1'b0);
      lat = 0; ndv = 0; nerr = 0; bad = 0;
      for (int c = 1; c <= 3 * t + 4; c++) begin
         if (!bus_ok(obs[d], c, t)) bad++;
         if (obs[d].dv)  begin ndv++;  lat = c; end
         if (obs[d].err) begin nerr++; lat = c; end
         @(negedge clk);
      end
   endtask

   // Bus invariants on every cycle of both instances
   always @(negedge clk) begin
      if (rst10 && ((bus10.ad_oe && !bus10.rd_n) || (!bus10.wr_n && bus10.ad_n) || (dv10 && er10)))
         viol++;
      if (rst2 && ((bus2.ad_oe && !bus2.rd_n) || (!bus2.wr_n && bus2.ad_n) || (dv2 && er2)))
         viol++;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int lat, ndv, nerr, bad, np, nidle, pos_bad, t;

      tab[0]  = '{8'h12, 1'b1, 8'h12, 4'd11};
      tab[1]  = '{8'h01, 1'b1, 8'h01, 4'd0};
      tab[2]  = '{8'h05, 1'b1, 8'h05, 4'd4};
      tab[3]  = '{8'h13, 1'b0, 8'h05, 4'd4};
      tab[4]  = '{8'h00, 1'b0, 8'h05, 4'd4};
      tab[5]  = '{8'h0A, 1'b0, 8'h05, 4'd4};
      tab[6]  = '{8'hFF, 1'b0, 8'h05, 4'd4};
      tab[7]  = '{8'h09, 1'b1, 8'h09, 4'd8};
      tab[8]  = '{8'h10, 1'b1, 8'h10, 4'd9};
      tab[9]  = '{8'h19, 1'b0, 8'h10, 4'd9};
      tab[10] = '{8'h11, 1'b1, 8'h11, 4'd10};
      tab[11] = '{8'h20, 1'b0, 8'h11, 4'd10};

      rst10 = 1'b0; rst2 = 1'b0; ini10 = 1'b0; ini2 = 1'b0;
      bus10.ad_in = 8'h00; bus2.ad_in = 8'h00;
      repeat (3) @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_bus%0d", d),
             {obs[d].cs_n, obs[d].rd_n, obs[d].wr_n, obs[d].ad_n, obs[d].ad_oe}, 5'b11110);
         chk($sformatf("rst_ad_out%0d", d), obs[d].ad_out, 8'h00);
         chk($sformatf("rst_mes_bcd%0d", d), obs[d].mes_bcd, 8'h01);
         chk($sformatf("rst_mes_bin%0d", d), obs[d].mes_bin, 4'd0);
         chk($sformatf("rst_flags%0d", d), {obs[d].ocupado, obs[d].dv, obs[d].err}, 3'b000);
      end
      rst10 = 1'b1; rst2 = 1'b1;
      @(negedge clk);

      // First read with T_FASE=10: pulse 31 cycles after acceptance
      txn(0, 10, 8'h07, lat, ndv, nerr, bad);
      chk("t1_latency", lat, 31);
      chk("t1_pulses", {ndv[3:0], nerr[3:0]}, 8'h10);
      chk("t1_timing", bad, 0);
      chk("t1_mes_bcd", obs[0].mes_bcd, 8'h07);
      chk("t1_mes_bin", obs[0].mes_bin, 4'd6);

      for (int d = 0; d < 2; d++) begin
         t = (d == 0) ? 10 : 2;
         for (int i = 0; i < 12; i++) begin
            txn(d, t, tab[i].ad, lat, ndv, nerr, bad);
            chk($sformatf("tab%0d_%0d_latency", d, i), lat, 3 * t + 1);
            chk($sformatf("tab%0d_%0d_pulses", d, i), {ndv[3:0], nerr[3:0]},
                tab[i].ok ? 8'h10 : 8'h01);
            chk($sformatf("tab%0d_%0d_timing", d, i), bad, 0);
            chk($sformatf("tab%0d_%0d_mes_bcd", d, i), obs[d].mes_bcd, tab[i].bcd);
            chk($sformatf("tab%0d_%0d_mes_bin", d, i), obs[d].mes_bin, tab[i].bin);
         end
      end

      // iniciar held high on T_FASE=2: a transaction every 8 cycles, REPOSO between
      @(negedge clk);
      set_ad(1, 8'h12);
      ini2 = 1'b1;
      @(negedge clk);
      np = 0; nidle = 0; pos_bad = 0;
      for (int c = 1; c <= 24; c++) begin
         if (dv2) begin np++; if (c % 8 != 7) pos_bad++; end
         if (er2) pos_bad++;
         if (!oc2) begin nidle++; if (c % 8 != 0) pos_bad++; end
         if (c == 24) ini2 = 1'b0;
         @(negedge clk);
      end
      chk("b2b_pulses", np, 3);
      chk("b2b_idle_cycles", nidle, 3);
      chk("b2b_positions", pos_bad, 0);
      chk("b2b_mes_bin", bin2, 4'd11);

      // Requests while busy (including during FIN) are dropped
      @(negedge clk);
      bus10.ad_in = 8'h04;
      ini10 = 1'b1;
      @(negedge clk);
      np = 0; nidle = 0;
      for (int c = 1; c <= 50; c++) begin
         ini10 = (c == 5 || c == 20 || c == 31);
         if (dv10 || er10) np++;
         if (c >= 32 && oc10) nidle++;
         @(negedge clk);
      end
      ini10 = 1'b0;
      chk("busy_pulses", np, 1);
      chk("busy_no_restart", nidle, 0);
      chk("busy_mes_bcd", bcd10, 8'h04);
      chk("busy_mes_bin", bin10, 4'd3);

      // Reset asserted in the middle of LECT
      @(negedge clk);
      bus10.ad_in = 8'h08;
      ini10 = 1'b1;
      @(negedge clk);
      ini10 = 1'b0;
      repeat (24) @(negedge clk);
      chk("pre_rst_lect", {bus10.cs_n, bus10.rd_n, bus10.ad_oe}, 3'b000);
      rst10 = 1'b0;
      #1;
      chk("mid_rst_bus", {bus10.cs_n, bus10.rd_n, bus10.wr_n, bus10.ad_n, bus10.ad_oe}, 5'b11110);
      chk("mid_rst_mes", {bcd10, bin10}, {8'h01, 4'd0});
      chk("mid_rst_ocupado", oc10, 1'b0);
      np = 0; nidle = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 2) rst10 = 1'b1;
         if (dv10 || er10) np++;
         if (oc10) nidle++;
      end
      chk("mid_rst_no_pulse", np, 0);
      chk("mid_rst_idle", nidle, 0);
      txn(0, 10, 8'h03, lat, ndv, nerr, bad);
      chk("post_rst_latency", lat, 31);
      chk("post_rst_timing", bad, 0);
      chk("post_rst_mes", {bcd10, bin10}, {8'h03, 4'd2});

      chk("bus_invariants", viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
